// File: rtl/int_seq_pkg.sv
// Shared types and constants for the 6502 exception sequencer.
package int_seq_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CYC_W  = 3;
  localparam int unsigned SEL_W  = 2;

  // Sequence position; the encoding doubles as the SEQ_CYC value.
  typedef enum logic [CYC_W-1:0] {
    ST_IDLE = 3'd0,
    ST_C1   = 3'd1,
    ST_C2   = 3'd2,
    ST_C3   = 3'd3,
    ST_C4   = 3'd4,
    ST_C5   = 3'd5,
    ST_C6   = 3'd6,
    ST_C7   = 3'd7
  } state_e;

  // Exception source that owns the running sequence.
  typedef enum logic [1:0] {
    SRC_RES = 2'd0,
    SRC_NMI = 2'd1,
    SRC_IRQ = 2'd2,
    SRC_BRK = 2'd3
  } src_e;

  // Vector offsets relative to the NMI vector low byte.
  localparam logic [ADDR_W-1:0] VOFF_NMI = 16'd0;
  localparam logic [ADDR_W-1:0] VOFF_RES = 16'd2;
  localparam logic [ADDR_W-1:0] VOFF_IRQ = 16'd4;

  // Push data selection codes.
  localparam logic [SEL_W-1:0] PUSH_PCH = 2'd0;
  localparam logic [SEL_W-1:0] PUSH_PCL = 2'd1;
  localparam logic [SEL_W-1:0] PUSH_P   = 2'd2;

  // Registered output bundle driven onto the bus-control ports.
  typedef struct packed {
    logic              int_take;
    logic              seq_busy;
    logic [CYC_W-1:0]  seq_cyc;
    logic              push_en;
    logic              stack_rd;
    logic [SEL_W-1:0]  push_sel;
    logic              b_out;
    logic              vec_rd;
    logic [ADDR_W-1:0] vec_addr;
    logic              set_i;
    logic              nmi_ack;
  } seq_out_t;

  // C3..C5 are the stack cycles (pushes, or reads during reset).
  function automatic logic is_stack_cyc(input state_e st);
    return (st == ST_C3) || (st == ST_C4) || (st == ST_C5);
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI falling-edge latch: holds a pending flag until the sequencer consumes it.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic n_nmi_i,
  input  logic clr_i,
  output logic edge_c_o,
  output logic pend_o
);

  logic hist_q;
  logic pend_q;
  logic pend_d;

  // A 1->0 transition of the pin relative to the previous sample.
  assign edge_c_o = hist_q & ~n_nmi_i;

  // A new edge wins over a same-cycle clear; edges while pending are absorbed.
  always_comb begin
    pend_d = pend_q;
    if (edge_c_o) begin
      pend_d = 1'b1;
    end else if (clr_i) begin
      pend_d = 1'b0;
    end
  end

  // Pin history and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      hist_q <= n_nmi_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/int_sequencer.sv
// Exception sequencer: arbitrates RES/NMI/IRQ/BRK and runs the shared 7-cycle
// BRK sequence, driving registered bus-control strobes for each cycle.
module int_sequencer
  import int_seq_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = 16'hFFFA,
  parameter bit          HIJACK   = 1'b1
) (
  input  logic        PHI0,
  input  logic        n_RES,
  input  logic        n_NMI,
  input  logic        n_IRQ,
  input  logic        I_FLAG,
  input  logic        RDY,
  input  logic        INSN_END,
  input  logic        BRK_OP,
  output logic        INT_TAKE,
  output logic        SEQ_BUSY,
  output logic [2:0]  SEQ_CYC,
  output logic        PUSH_EN,
  output logic        STACK_RD,
  output logic [1:0]  PUSH_SEL,
  output logic        B_OUT,
  output logic        VEC_RD,
  output logic [15:0] VEC_ADDR,
  output logic        SET_I,
  output logic        NMI_ACK
);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              res_pend_q, res_pend_d;
  seq_out_t          out_q, out_d;

  logic nmi_pend;
  logic nmi_edge_c;
  logic nmi_clr_c;
  logic irq_ok_c;
  logic advance_c;
  logic use_nmi_vec_c;

  // Consume the pending NMI only when C6 actually completes (not on stall edges).
  assign nmi_clr_c = out_q.nmi_ack & RDY;

  nmi_edge_detect u_nmi_edge (
    .clk      (PHI0),
    .rst_n    (n_RES),
    .n_nmi_i  (n_NMI),
    .clr_i    (nmi_clr_c),
    .edge_c_o (nmi_edge_c),
    .pend_o   (nmi_pend)
  );

  assign irq_ok_c = ~n_IRQ & ~I_FLAG;

  // Read cycles wait for RDY; true push cycles always proceed.
  assign advance_c = RDY | (is_stack_cyc(state_q) & (src_q != SRC_RES));

  // An NMI that is pending (or arriving) at the end of C5 can steal the vector.
  assign use_nmi_vec_c = (src_q == SRC_NMI) |
                         (HIJACK & (nmi_pend | nmi_edge_c));

  // Next-state, source capture and vector latch.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    vec_d      = vec_q;
    res_pend_d = res_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (res_pend_q) begin
          state_d    = ST_C1;
          src_d      = SRC_RES;
          res_pend_d = 1'b0;
        end else if (INSN_END && nmi_pend) begin
          state_d = ST_C1;
          src_d   = SRC_NMI;
        end else if (INSN_END && irq_ok_c) begin
          state_d = ST_C1;
          src_d   = SRC_IRQ;
        end else if (BRK_OP) begin
          state_d = ST_C2;
          src_d   = SRC_BRK;
        end
      end
      ST_C1: if (advance_c) state_d = ST_C2;
      ST_C2: if (advance_c) state_d = ST_C3;
      ST_C3: if (advance_c) state_d = ST_C4;
      ST_C4: if (advance_c) state_d = ST_C5;
      ST_C5: begin
        if (src_q == SRC_RES) begin
          vec_d = ADDR_W'(VEC_BASE + VOFF_RES);
        end else if (use_nmi_vec_c) begin
          vec_d = ADDR_W'(VEC_BASE + VOFF_NMI);
        end else begin
          vec_d = ADDR_W'(VEC_BASE + VOFF_IRQ);
        end
        if (advance_c) state_d = ST_C6;
      end
      ST_C6: if (advance_c) state_d = ST_C7;
      ST_C7: if (advance_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode for the cycle being entered; registered so strobes are glitch-free.
  always_comb begin
    out_d = '0;

    out_d.int_take = (state_d == ST_C1);
    out_d.seq_busy = (state_d != ST_IDLE);
    out_d.seq_cyc  = CYC_W'(state_d);

    if (is_stack_cyc(state_d)) begin
      out_d.push_en  = (src_d != SRC_RES);
      out_d.stack_rd = (src_d == SRC_RES);
    end

    case (state_d)
      ST_C3:   out_d.push_sel = PUSH_PCH;
      ST_C4:   out_d.push_sel = PUSH_PCL;
      ST_C5:   out_d.push_sel = PUSH_P;
      default: out_d.push_sel = PUSH_PCH;
    endcase

    out_d.b_out = (state_d == ST_C5) && (src_d == SRC_BRK);

    if (state_d == ST_C6) begin
      out_d.vec_rd   = 1'b1;
      out_d.vec_addr = vec_d;
      out_d.nmi_ack  = (vec_d == ADDR_W'(VEC_BASE + VOFF_NMI));
    end else if (state_d == ST_C7) begin
      out_d.vec_rd   = 1'b1;
      out_d.vec_addr = ADDR_W'(vec_d + 16'd1);
      out_d.set_i    = 1'b1;
    end
  end

  // State, latched source/vector, reset-pending flag and output registers.
  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_RES;
      vec_q      <= '0;
      res_pend_q <= 1'b1;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      vec_q      <= vec_d;
      res_pend_q <= res_pend_d;
      out_q      <= out_d;
    end
  end

  assign INT_TAKE = out_q.int_take;
  assign SEQ_BUSY = out_q.seq_busy;
  assign SEQ_CYC  = out_q.seq_cyc;
  assign PUSH_EN  = out_q.push_en;
  assign STACK_RD = out_q.stack_rd;
  assign PUSH_SEL = out_q.push_sel;
  assign B_OUT    = out_q.b_out;
  assign VEC_RD   = out_q.vec_rd;
  assign VEC_ADDR = out_q.vec_addr;
  assign SET_I    = out_q.set_i;
  assign NMI_ACK  = out_q.nmi_ack;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed self-checking bench for int_sequencer.
module tb_int_sequencer;

  logic        PHI0;
  logic        n_RES;
  logic        n_NMI;
  logic        n_IRQ;
  logic        I_FLAG;
  logic        RDY;
  logic        INSN_END;
  logic        BRK_OP;
  logic        INT_TAKE;
  logic        SEQ_BUSY;
  logic [2:0]  SEQ_CYC;
  logic        PUSH_EN;
  logic        STACK_RD;
  logic [1:0]  PUSH_SEL;
  logic        B_OUT;
  logic        VEC_RD;
  logic [15:0] VEC_ADDR;
  logic        SET_I;
  logic        NMI_ACK;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  int_sequencer #(.VEC_BASE(16'hFFFA), .HIJACK(1'b1)) dut (
    .PHI0     (PHI0),
    .n_RES    (n_RES),
    .n_NMI    (n_NMI),
    .n_IRQ    (n_IRQ),
    .I_FLAG   (I_FLAG),
    .RDY      (RDY),
    .INSN_END (INSN_END),
    .BRK_OP   (BRK_OP),
    .INT_TAKE (INT_TAKE),
    .SEQ_BUSY (SEQ_BUSY),
    .SEQ_CYC  (SEQ_CYC),
    .PUSH_EN  (PUSH_EN),
    .STACK_RD (STACK_RD),
    .PUSH_SEL (PUSH_SEL),
    .B_OUT    (B_OUT),
    .VEC_RD   (VEC_RD),
    .VEC_ADDR (VEC_ADDR),
    .SET_I    (SET_I),
    .NMI_ACK  (NMI_ACK)
  );

  initial PHI0 = 1'b0;
  always #5 PHI0 = ~PHI0;

  logic [12:0] obs_ctl;
  assign obs_ctl = {INT_TAKE, SEQ_BUSY, SEQ_CYC, PUSH_EN, STACK_RD, PUSH_SEL,
                    B_OUT, VEC_RD, SET_I, NMI_ACK};

  // Expected control strobes for sequence cycle c (0 = idle).
  function automatic logic [12:0] exp_ctl(input int c, input bit res,
                                          input bit brk, input bit ack);
    logic [2:0] cyc;
    logic [1:0] sel;
    logic       stk;
    cyc = 3'(c);
    sel = (c == 4) ? 2'd1 : (c == 5) ? 2'd2 : 2'd0;
    stk = (c >= 3) && (c <= 5);
    return {c == 1, c != 0, cyc, stk && !res, stk && res, sel,
            (c == 5) && brk, c >= 6, c == 7, (c == 6) && ack};
  endfunction

  function automatic logic [15:0] exp_addr(input int c, input logic [15:0] vec);
    if (c == 6) return vec;
    if (c == 7) return 16'(vec + 16'd1);
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge PHI0);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input int c, input bit res,
                         input bit brk, input bit ack, input logic [15:0] vec);
    check($sformatf("%s_c%0d_ctl", tag, c), 16'(obs_ctl), 16'(exp_ctl(c, res, brk, ack)));
    check($sformatf("%s_c%0d_addr", tag, c), VEC_ADDR, exp_addr(c, vec));
  endtask

  // Walk one sequence from cycle 'first' to idle with optional NMI fall,
  // RDY stall (held cycle) and RDY drop (must not stall; BRK_OP pulsed too).
  task automatic run_seq(input string tag, input int first, input bit res,
                         input bit brk, input bit ack, input logic [15:0] vec,
                         input int nmi_at, input int stall_at, input int stall_n,
                         input int drop_at);
    for (int c = first; c <= 7; c++) begin
      step();
      chk_cyc(tag, c, res, brk, ack, vec);
      if (c == first) begin
        INSN_END = 1'b0;
        BRK_OP   = 1'b0;
        n_IRQ    = 1'b1;
      end
      if (c == drop_at + 1) begin
        RDY    = 1'b1;
        BRK_OP = 1'b0;
      end
      if (c == nmi_at) n_NMI = 1'b0;
      if (c == stall_at) begin
        RDY = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          step();
          chk_cyc({tag, "_stall"}, c, res, brk, ack, vec);
        end
        RDY = 1'b1;
      end
      if (c == drop_at) begin
        RDY    = 1'b0;
        BRK_OP = 1'b1;
      end
    end
    step();
    chk_cyc({tag, "_end"}, 0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_RES    = 1'b0;
    n_NMI    = 1'b1;
    n_IRQ    = 1'b1;
    I_FLAG   = 1'b0;
    RDY      = 1'b1;
    INSN_END = 1'b0;
    BRK_OP   = 1'b0;

    // Reset state.
    step();
    step();
    chk_cyc("rst", 0, 1'b0, 1'b0, 1'b0, 16'h0);

    // Reset sequence, with a RDY stall on the C4 stack read.
    n_RES = 1'b1;
    run_seq("res", 1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 0, 4, 2, 0);

    // IRQ masked by I: no take.
    I_FLAG   = 1'b1;
    n_IRQ    = 1'b0;
    INSN_END = 1'b1;
    step();
    chk_cyc("irq_masked", 0, 1'b0, 1'b0, 1'b0, 16'h0);

    // IRQ taken; released after C1, RDY low in C3 must not stall, 3-cycle C6 stall.
    I_FLAG = 1'b0;
    run_seq("irq", 1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 0, 6, 3, 3);

    // BRK with NMI falling in C4: hijacked to NMI vector, B set, ack in C6.
    BRK_OP = 1'b1;
    run_seq("brk_hijack", 2, 1'b0, 1'b1, 1'b1, 16'hFFFA, 4, 0, 0, 0);
    n_NMI = 1'b1;

    // NMI consumed by the hijack: no retake on the next INSN_END.
    INSN_END = 1'b1;
    step();
    chk_cyc("nmi_consumed", 0, 1'b0, 1'b0, 1'b0, 16'h0);
    INSN_END = 1'b0;

    // BRK with NMI falling in C6: too late, stays pending.
    BRK_OP = 1'b1;
    run_seq("brk_late_nmi", 2, 1'b0, 1'b1, 1'b0, 16'hFFFE, 6, 0, 0, 0);
    n_NMI = 1'b1;

    // Pending NMI taken at next INSN_END.
    INSN_END = 1'b1;
    run_seq("nmi_pending", 1, 1'b0, 1'b0, 1'b1, 16'hFFFA, 0, 0, 0, 0);

    // n_NMI held low for 20+ cycles: exactly one NMI sequence.
    n_NMI = 1'b0;
    step();
    INSN_END = 1'b1;
    run_seq("nmi_level", 1, 1'b0, 1'b0, 1'b1, 16'hFFFA, 0, 0, 0, 0);
    INSN_END = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("nmi_level_idle%0d", i), 16'(obs_ctl), 16'h0000);
    end
    INSN_END = 1'b0;
    n_NMI    = 1'b1;
    step();

    // Reset asserted in C5 of an IRQ sequence aborts at once.
    n_IRQ    = 1'b0;
    INSN_END = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("abort_c%0d", c), 16'(SEQ_CYC), 16'(c));
      if (c == 1) begin
        INSN_END = 1'b0;
        n_IRQ    = 1'b1;
      end
    end
    #2;
    n_RES = 1'b0;
    #1;
    check("abort_ctl", 16'(obs_ctl), 16'h0000);
    check("abort_addr", VEC_ADDR, 16'h0000);
    step();
    step();
    check("abort_hold", 16'(obs_ctl), 16'h0000);
    n_RES = 1'b1;
    run_seq("res2", 1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
